// File: rtl/multi_cycle_control_unit.sv
// Sequenced opcode control unit: accepts one opcode, runs a multi-cycle EXECUTE phase, then one WRITEBACK cycle.
// Latency: accept at cycle 0, EXECUTE 1..L (L = 1, MUL_LATENCY or DIV_LATENCY), WRITEBACK at L+1, ready again at L+2.
// Backpressure: instrReady is high only in IDLE; instrValid at any other time is ignored and the opcode is not captured.
//
// Ports:
//   clk, rstN               clock (rising edge) and asynchronous active-low reset
//   instrValid/instrReady   opcode handshake; opCode is sampled when both are high
//   opCode                  instruction opcode (values >= 8 are illegal, 3'b111 is HALT)
//   resume                  single-cycle pulse that leaves HALT
//   aluStart                pulse on the first EXECUTE cycle
//   registerWriteEnable     high only in WRITEBACK
//   operationType           000 pass, 001 add, 010 sub, 011 mul, 100 div
//   destinationSource       00 none, 01 memory/load, 10 ALU, 11 halt
//   busy / halted           state is EXECUTE or WRITEBACK / state is HALT
//   illegalOp               pulse the cycle after an illegal opcode is accepted
//   retiredCount            completed WRITEBACKs, wrapping
// Parameter ranges: OP_WIDTH >= 3, MUL_LATENCY and DIV_LATENCY in 1..255.
module multi_cycle_control_unit #(
  parameter int OP_WIDTH    = 3,
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   instrValid,
  output logic                   instrReady,
  input  logic [OP_WIDTH-1:0]    opCode,
  input  logic                   resume,
  output logic                   aluStart,
  output logic                   registerWriteEnable,
  output logic [2:0]             operationType,
  output logic [1:0]             destinationSource,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegalOp,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXECUTE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_HALT      = 2'd3
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  state_e                 state_q, state_d;
  logic [2:0]             opcode_q, opcode_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  // Zero-extending to 32 bits keeps the range check valid for OP_WIDTH == 3,
  // where no opcode can be illegal.
  logic op_illegal;
  assign op_illegal = (32'(opCode) >= 32'd8);

  // EXECUTE length minus one, loaded into the down-counter on accept.
  function automatic logic [7:0] latency_m1(input logic [2:0] op);
    case (op)
      OP_MUL:  return 8'(MUL_LATENCY - 1);
      OP_DIV:  return 8'(DIV_LATENCY - 1);
      default: return 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      opcode_q  <= 3'd0;
      cnt_q     <= 8'd0;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    illegal_d = 1'b0;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (instrValid) begin
          opcode_d = opCode[2:0];
          if (op_illegal) begin
            // Rejected in place: stay ready, flag it next cycle.
            illegal_d = 1'b1;
          end else if (opCode[2:0] == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXECUTE;
            cnt_d   = latency_m1(opCode[2:0]);
            first_d = 1'b1;
          end
        end
      end
      S_EXECUTE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_WRITEBACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WRITEBACK: begin
        retired_d = retired_q + COUNT_WIDTH'(1);
        state_d   = S_IDLE;
      end
      S_HALT: begin
        // instrValid is not looked at here, so resume always wins.
        if (resume) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode uses only registered state, never opCode directly.
  always_comb begin
    operationType     = 3'b000;
    destinationSource = 2'b00;
    case (state_q)
      S_EXECUTE, S_WRITEBACK: begin
        case (opcode_q)
          OP_LOAD:  destinationSource = 2'b01;
          OP_STORE: destinationSource = 2'b10;
          OP_ADD:  begin operationType = 3'b001; destinationSource = 2'b10; end
          OP_SUB:  begin operationType = 3'b010; destinationSource = 2'b10; end
          OP_MUL:  begin operationType = 3'b011; destinationSource = 2'b10; end
          OP_DIV:  begin operationType = 3'b100; destinationSource = 2'b10; end
          default: begin operationType = 3'b000; destinationSource = 2'b00; end
        endcase
      end
      S_HALT:  destinationSource = 2'b11;
      default: destinationSource = 2'b00;
    endcase
  end

  assign instrReady          = (state_q == S_IDLE);
  assign busy                = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted              = (state_q == S_HALT);
  assign registerWriteEnable = (state_q == S_WRITEBACK);
  // first_q is only ever set on the transition into EXECUTE.
  assign aluStart            = first_q && (state_q == S_EXECUTE);
  assign illegalOp           = illegal_q;
  assign retiredCount        = retired_q;

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Parametrised, sequenced successor to the single-cycle opcode decoder of the 8-bit processor.
- Accepts one instruction opcode through a valid/ready handshake and holds it through a multi-cycle EXECUTE phase with per-operation latency (multiply/divide configurable).
- Produces write-enable, ALU operation type and destination source per phase, and provides HALT/resume and a retired-instruction counter.
- Sits between the instruction register and the register file/ALU.

Parameters:
OP_WIDTH, 3, opcode width (>=3); opcodes >= 8 are illegal.
MUL_LATENCY, 4, EXECUTE cycles for multiply (1..255).
DIV_LATENCY, 8, EXECUTE cycles for divide (1..255).
COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rstN  input  1  asynchronous active-low reset.
instrValid  input  1  opCode valid this cycle.
instrReady  output  1  unit can accept an opcode (state IDLE).
opCode  input  OP_WIDTH  instruction opcode.
resume  input  1  leave HALT (single-cycle pulse).
aluStart  output  1  one-cycle pulse on first EXECUTE cycle.
registerWriteEnable  output  1  register-file write, asserted only in WRITEBACK.
operationType  output  3  000 pass, 001 add, 010 sub, 011 mul, 100 div.
destinationSource  output  2  00 none, 01 memory/load, 10 ALU, 11 halt.
busy  output  1  state is EXECUTE or WRITEBACK.
halted  output  1  state is HALT.
illegalOp  output  1  one-cycle pulse when an illegal opcode is accepted.
retiredCount  output  COUNT_WIDTH  count of completed WRITEBACKs.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rstN low): immediately forces the following, mid-operation included, with no write issued:
  - state IDLE, latched opcode 0, latency counter 0, retiredCount 0;
  - aluStart, registerWriteEnable, busy, halted, illegalOp = 0; operationType 000; destinationSource 00; instrReady = 1.
- State machine: IDLE, EXECUTE, WRITEBACK, HALT.
- IDLE:
  - instrReady = 1.
  - On instrValid & instrReady, the opcode is latched.
  - Opcode 111 -> HALT.
  - Opcode >= 8 -> IDLE, with illegalOp pulsed the next cycle; nothing is executed or retired.
  - Otherwise -> EXECUTE, with the counter loaded with latency-1.
- Latency: 1 cycle for 000 NOP, 001 load, 010 store, 011 add, 100 sub; MUL_LATENCY for 101; DIV_LATENCY for 110.
- EXECUTE:
  - aluStart = 1 on the first cycle only.
  - operationType/destinationSource decoded from the latched opcode: 000->000/00, 001->000/01, 010->000/10, 011->001/10, 100->010/10, 101->011/10, 110->100/10.
  - Counter decrements each cycle; at 0 -> WRITEBACK.
- WRITEBACK:
  - One cycle; same decode held; registerWriteEnable = 1 for all legal non-halt opcodes.
  - retiredCount increments at the end of the cycle, wrapping from 2^COUNT_WIDTH-1 to 0.
  - -> IDLE.
- Timing: accept at cycle 0 -> EXECUTE cycles 1..L -> WRITEBACK at L+1 -> instrReady again at L+2.
- HALT:
  - halted = 1, instrReady = 0, destinationSource = 11, registerWriteEnable = 0.
  - resume -> IDLE next cycle. HALT is not counted as retired.
- instrValid while instrReady = 0 is ignored; the opcode is not captured.
- resume outside HALT is ignored.
- resume and instrValid in the same cycle while HALTed: resume wins, opCode is not accepted that cycle.
- busy, halted and instrReady are decoded from the state register; all other outputs are registered or state-decoded, with no combinational path from opCode.

Test Plan:
- Reset then ADD (011) with instrValid for 1 cycle -> aluStart at cycle 1; operationType 001 and destinationSource 10 in cycles 1-2; registerWriteEnable only at cycle 2; instrReady at cycle 3; retiredCount = 1.
- MUL (101) with MUL_LATENCY=4 -> busy cycles 1-5; WRITEBACK at cycle 5; operationType 011 throughout; single aluStart. Then DIV (110) with DIV_LATENCY=8 -> WRITEBACK 9 cycles after accept.
- HALT (111) -> halted = 1 and destinationSource = 11 from cycle 1; instrValid with ADD ignored for 5 cycles; resume -> IDLE; next ADD accepted and retired; retiredCount unchanged by the halt.
- OP_WIDTH=4, opCode 1010 -> illegalOp pulse for 1 cycle; no aluStart, no write, retiredCount unchanged; instrReady stays 1.
- COUNT_WIDTH=4, 16 back-to-back NOPs -> retiredCount wraps from 15 to 0 on the 16th WRITEBACK.
- rstN asserted during cycle 3 of a DIV -> all outputs return to reset values asynchronously; no registerWriteEnable; instrReady = 1 after release.
